fma16_mulseq: RTL and testbench
===============================

Name: fma16_mulseq

Overview:
- Sequential half-precision multiply stage that sits directly upstream of the fma16 add stage.
- Accepts x, y, z and the mul/add controls through a valid/ready handshake.
- Computes the sign, biased exponent and raw 22-bit significand product of x*y with an iterative shift-add multiplier.
- Presents product, fullPm and registered copies of x, y, z, mul and add to the add stage, and holds them until they are consumed.

Parameters:
- MANT_W, 10, stored mantissa width of the half-precision format.
- BIAS, 15, exponent bias.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has an operand set.
- in_ready  out  1  block can accept an operand set.
- x  in  16  multiplicand.
- y  in  16  multiplier.
- z  in  16  addend; passed through unchanged.
- mul  in  1  multiply enable; 0 means x*1.0.
- add  in  1  add enable; passed through.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  add stage consumes the result.
- product  out  16  truncated half-precision x*y.
- fullPm  out  22  raw product {1,xm}*{1,ym}.
- x_q  out  16  registered copy of x.
- y_q  out  16  registered copy of y.
- z_q  out  16  registered copy of z.
- mul_q  out  1  registered copy of mul.
- add_q  out  1  registered copy of add.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - the FSM goes to IDLE;
  - all outputs and internal registers are cleared;
  - in_ready=1 and out_valid=0 in IDLE.
- Reset asserted mid-operation abandons the calculation. No partial result is ever emitted.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, capture operands.
    - If a short-circuit case applies, go to DONE.
    - Otherwise go to BUSY with cnt=0, acc=0, multiplicand={1,xm}, multiplier={1,ym}.
  - BUSY: in_ready=0. Each cycle, if multiplier LSB=1, add the multiplicand (shifted by cnt) into the 22-bit acc. Shift the multiplier right by 1 and increment cnt. After iteration cnt=10 (11 iterations total), go to DONE.
  - DONE: out_valid=1 and all outputs are stable. On out_ready, go to IDLE; out_valid drops on the next edge.
- Latency:
  - 11 clock edges from the accept edge to out_valid.
  - Short-circuit cases take 1 edge.
- No overlap: in_ready=0 in BUSY and in DONE. in_valid outside IDLE is ignored.
- Sign: product[15] = x[15]^y[15].
- Exponent:
  - Pe = x[14:10]+y[14:10]-BIAS, computed modulo 32 (5-bit wrap, no saturation).
  - Add 1 when fullPm[21]=1.
- Mantissa (truncation only, no rounding):
  - fullPm[21]=1: product[9:0] = fullPm[20:11].
  - fullPm[21]=0: product[9:0] = fullPm[19:10].
- Short-circuit cases:
  - mul=0: product=x, fullPm={2'b01,x[9:0],10'b0}.
  - x or y equals zero (exponent=0 and mantissa=0): product={sign,15'b0}, fullPm=0.
  - Both cases take priority over BUSY.
- Subnormal, Inf and NaN inputs get no special handling. They are treated as normal numbers with the implicit 1 applied.
- Simultaneous out_ready and a new in_valid in DONE: in_valid is not accepted. It is sampled in IDLE on the following cycle.

Optional Feature:
- Macro: FMA16_MULSEQ_RADIX4_EN.
- Defined: BUSY consumes 2 multiplier bits per cycle, adding 0, 1, 2 or 3 times the shifted multiplicand. It takes 6 iterations (the last one uses only bit 10), so latency is 6 edges.
- Undefined: radix-2 with 11 edges.
- Result values are identical in both modes.

Decomposition:
- Shared package fma16_pkg holds:
  - FSM state enum: IDLE, BUSY, DONE;
  - constants BIAS=15, MANT_W=10, SIG_W=11, PROD_W=22;
  - a packed struct for the half-precision fields (sign, exp[4:0], mant[9:0]).
- One sub-module, fma16_shiftadd_dp: the acc/multiplicand/multiplier datapath with its iteration counter. The parent owns the FSM, handshake, exponent/sign logic and output registers.

Test Plan:
- x=16'h3E00, y=16'h4000, mul=1 -> after 11 edges: fullPm=22'h180000, product=16'h4200.
- x=16'h3E00, y=16'h3E00 -> fullPm=22'h240000 (bit21 set), product=16'h4080.
- x=16'hBC00, y=16'h0000 -> product=16'h8000, fullPm=0, out_valid after 1 edge.
- mul=0, x=16'h4500, y=16'h1234 -> product=16'h4500, fullPm=22'h140000.
- Hold out_ready=0 for 5 cycles in DONE -> all outputs stable, in_ready=0; then out_ready=1 -> IDLE on the next edge.
- Assert reset 4 edges into BUSY -> out_valid=0 and outputs cleared immediately; a new operation after reset completes with a correct result.

Source files
------------

// File: rtl/fma16_pkg.sv
// Shared definitions for the fma16 multiply stage: FSM states, format
// constants, half-precision field layout and the product packing helper.
package fma16_pkg;

    localparam int BIAS   = 15;
    localparam int MANT_W = 10;
    localparam int SIG_W  = 11;
    localparam int PROD_W = 22;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [4:0]        exp;
        logic [MANT_W-1:0] mant;
    } half_t;

    // Builds the truncated half-precision product from the operand fields and
    // the raw significand product. The exponent wraps modulo 32 on purpose:
    // the add stage sees exactly what the 5-bit adder produces.
    function automatic logic [15:0] packProduct(input half_t xh, input half_t yh,
                                                input logic [PROD_W-1:0] pm);
        logic [4:0]        pe;
        logic [MANT_W-1:0] pmant;
        pe = xh.exp + yh.exp - 5'(BIAS);
        if (pm[PROD_W-1]) begin
            pe    = pe + 5'd1;
            pmant = pm[20:11];
        end else begin
            pmant = pm[19:10];
        end
        return {xh.sign ^ yh.sign, pe, pmant};
    endfunction

endpackage

// File: rtl/fma16_shiftadd_dp.sv
// Iterative shift-add significand multiplier datapath for fma16_mulseq.
// Radix-2 by default (11 iterations); defining FMA16_MULSEQ_RADIX4_EN makes
// each iteration retire two multiplier bits (6 iterations).
import fma16_pkg::*;

module fma16_shiftadd_dp (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [SIG_W-1:0]  mcand_i,
    input  logic [SIG_W-1:0]  mplier_i,
    output logic [PROD_W-1:0] accNext_o,
    output logic              lastIter_o
);

    logic [PROD_W-1:0] acc_q, acc_d;
    logic [SIG_W-1:0]  mcand_q, mcand_d;
    logic [SIG_W-1:0]  mplier_q, mplier_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [4:0]        shiftAmt;
    logic [PROD_W-1:0] mcandExt;
    logic [PROD_W-1:0] partial;

`ifdef FMA16_MULSEQ_RADIX4_EN
    localparam logic [3:0] LAST_CNT = 4'd5;
    localparam int         STEP_BITS = 2;
    assign shiftAmt = {cnt_q, 1'b0};
    // The final iteration sees only bit 10, bit 11 is already shifted-in zero.
    assign partial  = (mplier_q[0] ? mcandExt : '0)
                    + (mplier_q[1] ? (mcandExt << 1) : '0);
`else
    localparam logic [3:0] LAST_CNT = 4'd10;
    localparam int         STEP_BITS = 1;
    assign shiftAmt = {1'b0, cnt_q};
    assign partial  = mplier_q[0] ? mcandExt : '0;
`endif

    assign mcandExt   = {{(PROD_W-SIG_W){1'b0}}, mcand_q} << shiftAmt;
    assign accNext_o  = acc_q + partial;
    assign lastIter_o = (cnt_q == LAST_CNT);

    // Load fresh operands on accept, otherwise accumulate one step per cycle.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = accNext_o;
            mplier_d = mplier_q >> STEP_BITS;
            cnt_d    = cnt_q + 4'd1;
        end
    end

    // Datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fma16_mulseq.sv
// Sequential half-precision multiply stage feeding the fma16 add stage.
// Owns the handshake FSM, sign/exponent logic and the result registers; the
// significand product comes from fma16_shiftadd_dp. Optional macro
// FMA16_MULSEQ_RADIX4_EN selects the two-bits-per-cycle datapath.
import fma16_pkg::*;

module fma16_mulseq (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    input  logic [15:0]       z,
    input  logic              mul,
    input  logic              add,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       product,
    output logic [PROD_W-1:0] fullPm,
    output logic [15:0]       x_q,
    output logic [15:0]       y_q,
    output logic [15:0]       z_q,
    output logic              mul_q,
    output logic              add_q
);

    state_t            state_q, state_d;
    logic              captureEn;
    logic              dpLoad;
    logic              dpStep;
    logic              dpLast;
    logic [PROD_W-1:0] accNext;
    logic [15:0]       product_q, product_d;
    logic [PROD_W-1:0] fullPm_q, fullPm_d;
    logic              xZero, yZero;

    assign xZero     = (x[14:0] == 15'd0);
    assign yZero     = (y[14:0] == 15'd0);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign fullPm    = fullPm_q;

    fma16_shiftadd_dp uDp (
        .clk        (clk),
        .reset      (reset),
        .load_i     (dpLoad),
        .step_i     (dpStep),
        .mcand_i    ({1'b1, x[MANT_W-1:0]}),
        .mplier_i   ({1'b1, y[MANT_W-1:0]}),
        .accNext_o  (accNext),
        .lastIter_o (dpLast)
    );

    // Next-state and result selection; bypass cases skip the datapath entirely.
    always_comb begin
        state_d   = state_q;
        captureEn = 1'b0;
        dpLoad    = 1'b0;
        dpStep    = 1'b0;
        product_d = product_q;
        fullPm_d  = fullPm_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    captureEn = 1'b1;
                    if (!mul) begin
                        product_d = x;
                        fullPm_d  = {2'b01, x[MANT_W-1:0], 10'b0};
                        state_d   = DONE;
                    end else if (xZero || yZero) begin
                        product_d = {x[15] ^ y[15], 15'b0};
                        fullPm_d  = '0;
                        state_d   = DONE;
                    end else begin
                        dpLoad  = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dpStep = 1'b1;
                if (dpLast) begin
                    product_d = packProduct(half_t'(x_q), half_t'(y_q), accNext);
                    fullPm_d  = accNext;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result registers; held unchanged while waiting in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product_q <= '0;
            fullPm_q  <= '0;
        end else begin
            product_q <= product_d;
            fullPm_q  <= fullPm_d;
        end
    end

    // Operand copies captured on the accept edge only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            mul_q <= 1'b0;
            add_q <= 1'b0;
        end else if (captureEn) begin
            x_q   <= x;
            y_q   <= y;
            z_q   <= z;
            mul_q <= mul;
            add_q <= add;
        end
    end

endmodule

// File: tb/tb_fma16_mulseq.sv
// Self-checking bench for fma16_mulseq: a vector table run through a
// scoreboard, plus hand-written hold, simultaneous-handshake and reset cases.
module tb_fma16_mulseq;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic        mul;
        logic        add;
        logic [15:0] expProd;
        logic [21:0] expPm;
        logic        shortCut;
    } vec_t;

`ifdef FMA16_MULSEQ_RADIX4_EN
    localparam int ITERS = 6;
`else
    localparam int ITERS = 11;
`endif
    localparam int NVEC = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0, y = '0, z = '0;
    logic        mul = 1'b0, add = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic [21:0] fullPm;
    logic [15:0] x_q, y_q, z_q;
    logic        mul_q, add_q;

    int testsRun = 0;
    int failures = 0;
    vec_t vecs[NVEC];
    vec_t sbQueue[$];

    fma16_mulseq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .mul       (mul),
        .add       (add),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .fullPm    (fullPm),
        .x_q       (x_q),
        .y_q       (y_q),
        .z_q       (z_q),
        .mul_q     (mul_q),
        .add_q     (add_q)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        testsRun++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Waits for in_ready, presents one operand set for exactly the accept edge.
    task automatic applyStimulus(input vec_t v, input bit doPush);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("inReadyTimeout", 32'd0, 32'd1);
        x = v.x; y = v.y; z = v.z; mul = v.mul; add = v.add;
        in_valid = 1'b1;
        if (doPush) sbQueue.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; counts further edges until out_valid.
    task automatic collectResult(input int expEdges);
        int   edges = 0;
        vec_t e;
        checkOutput("inReadyAfterAccept", {31'd0, in_ready}, 32'd0);
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid) begin
            checkOutput("outValidTimeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", edges, expEdges);
            if (sbQueue.size() == 0) begin
                checkOutput("scoreboardEmpty", 32'd0, 32'd1);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("product", {16'd0, product}, {16'd0, e.expProd});
                checkOutput("fullPm", {10'd0, fullPm}, {10'd0, e.expPm});
                checkOutput("x_q", {16'd0, x_q}, {16'd0, e.x});
                checkOutput("y_q", {16'd0, y_q}, {16'd0, e.y});
                checkOutput("z_q", {16'd0, z_q}, {16'd0, e.z});
                checkOutput("mul_q", {31'd0, mul_q}, {31'd0, e.mul});
                checkOutput("add_q", {31'd0, add_q}, {31'd0, e.add});
            end
        end
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v, 1'b1);
        collectResult(v.shortCut ? 0 : ITERS);
        @(posedge clk); #1;
        checkOutput("outValidDrop", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           x        y        z       mul   add   product  fullPm       short
        vecs[0]  = '{16'h3E00, 16'h4000, 16'h1234, 1'b1, 1'b1, 16'h4200, 22'h180000, 1'b0};
        vecs[1]  = '{16'h3E00, 16'h3E00, 16'hABCD, 1'b1, 1'b0, 16'h4080, 22'h240000, 1'b0};
        vecs[2]  = '{16'hBC00, 16'h0000, 16'h5555, 1'b1, 1'b1, 16'h8000, 22'h000000, 1'b1};
        vecs[3]  = '{16'h4500, 16'h1234, 16'h0F0F, 1'b0, 1'b1, 16'h4500, 22'h140000, 1'b1};
        vecs[4]  = '{16'h3C00, 16'h3C00, 16'h0001, 1'b1, 1'b0, 16'h3C00, 22'h100000, 1'b0};
        vecs[5]  = '{16'hC000, 16'h3C00, 16'h8000, 1'b1, 1'b1, 16'hC000, 22'h100000, 1'b0};
        vecs[6]  = '{16'h3FFF, 16'h3FFF, 16'h7FFF, 1'b1, 1'b0, 16'h43FE, 22'h3FF001, 1'b0};
        vecs[7]  = '{16'h0000, 16'hC500, 16'h2222, 1'b1, 1'b1, 16'h8000, 22'h000000, 1'b1};
        vecs[8]  = '{16'h0400, 16'h0400, 16'h3333, 1'b1, 1'b0, 16'h4C00, 22'h100000, 1'b0};
        vecs[9]  = '{16'hBC00, 16'h0000, 16'h4444, 1'b0, 1'b0, 16'hBC00, 22'h100000, 1'b1};
        vecs[10] = '{16'h7C00, 16'h3C00, 16'h6666, 1'b1, 1'b1, 16'h7C00, 22'h100000, 1'b0};
        vecs[11] = '{16'h4100, 16'h4200, 16'h7777, 1'b1, 1'b0, 16'h4780, 22'h1E0000, 1'b0};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstProduct", {16'd0, product}, 32'd0);
        checkOutput("rstFullPm", {10'd0, fullPm}, 32'd0);
        checkOutput("rstXq", {16'd0, x_q}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            runVector(vecs[i]);
        end

        // Hold the result in DONE; stray in_valid must not disturb it.
        out_ready = 1'b0;
        applyStimulus(vecs[0], 1'b1);
        collectResult(ITERS);
        x = 16'h1111; y = 16'h2222; mul = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("holdOutValid", {31'd0, out_valid}, 32'd1);
            checkOutput("holdInReady", {31'd0, in_ready}, 32'd0);
            checkOutput("holdProduct", {16'd0, product}, 32'h4200);
            checkOutput("holdFullPm", {10'd0, fullPm}, 32'h180000);
            checkOutput("holdXq", {16'd0, x_q}, 32'h3E00);
        end
        // Consume with in_valid still high: it must not be taken on this edge.
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("consumeOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("consumeInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("consumeXq", {16'd0, x_q}, 32'h3E00);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("idleStays", {31'd0, in_ready}, 32'd1);

        // Reset four edges into BUSY abandons the operation.
        applyStimulus(vecs[11], 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midBusyOutValid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("midRstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("midRstInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("midRstProduct", {16'd0, product}, 32'd0);
        checkOutput("midRstFullPm", {10'd0, fullPm}, 32'd0);
        checkOutput("midRstXq", {16'd0, x_q}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        runVector(vecs[1]);

        checkOutput("scoreboardDrained", sbQueue.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
